adc_dly_tap_cal: RTL and testbench



---
 rtl/adc_dly_tap_cal_if.sv | 27 ++
 rtl/adc_dly_tap_cal.sv | 176 +++++++++++++++++
 tb/tb_adc_dly_tap_cal.sv | 220 ++++++++++++++++++++++
 3 files changed

// File: rtl/adc_dly_tap_cal_if.sv
// Calibration bundle between the ADC deserialiser/controller and adc_dly_tap_cal.
// Latency: none, this is wiring only. Backpressure: none; every signal is level or pulse with no handshake.
// Ports: master = pattern source/supervisor (drives CAL_START, CHn_DATA); slave = calibration engine.
interface adc_dly_tap_cal_if;
    logic        CAL_START;
    logic [15:0] CH1_DATA;
    logic [15:0] CH2_DATA;
    logic [15:0] CH3_DATA;
    logic [15:0] CH4_DATA;
    logic [4:0]  DLY_TAP_OUT;
    logic        DLY_LD;
    logic        CAL_BUSY;
    logic        CAL_DONE;
    logic        CAL_FAIL;
    logic [4:0]  WIN_START;
    logic [5:0]  WIN_LEN;

    modport master (
        output CAL_START, CH1_DATA, CH2_DATA, CH3_DATA, CH4_DATA,
        input  DLY_TAP_OUT, DLY_LD, CAL_BUSY, CAL_DONE, CAL_FAIL, WIN_START, WIN_LEN
    );

    modport slave (
        input  CAL_START, CH1_DATA, CH2_DATA, CH3_DATA, CH4_DATA,
        output DLY_TAP_OUT, DLY_LD, CAL_BUSY, CAL_DONE, CAL_FAIL, WIN_START, WIN_LEN
    );
endinterface

// File: rtl/adc_dly_tap_cal.sv
// IDELAY tap sweep: find the widest error-free tap window across CH1..CH4 and load its centre.
// Latency: 1 + SETTLE_CYC + CHECK_CYC + 1 cycles per tap, 32 taps, plus 1 CENTER cycle (8769 at defaults).
// Backpressure: none; CAL_START is only honoured in IDLE/DONE/FAIL and ignored while busy.
// Ports: ADCLK_100M (clock), IO_RST_N (async active-low reset), cal (slave side of adc_dly_tap_cal_if).
module adc_dly_tap_cal #(
    parameter int unsigned NUM_TAPS    = 32,
    parameter int unsigned SETTLE_CYC  = 16,
    parameter int unsigned CHECK_CYC   = 256,
    parameter logic [15:0] PATTERN     = 16'hA55A,
    parameter int unsigned MIN_WIN     = 4,
    parameter logic [4:0]  DEFAULT_TAP = 5'd16
) (
    input  logic             ADCLK_100M,
    input  logic             IO_RST_N,
    adc_dly_tap_cal_if.slave cal
);

    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_SET_TAP = 3'd1;
    localparam logic [2:0] ST_SETTLE  = 3'd2;
    localparam logic [2:0] ST_CHECK   = 3'd3;
    localparam logic [2:0] ST_NEXT    = 3'd4;
    localparam logic [2:0] ST_CENTER  = 3'd5;
    localparam logic [2:0] ST_DONE    = 3'd6;
    localparam logic [2:0] ST_FAIL    = 3'd7;

    localparam logic [4:0]  LAST_TAP   = 5'(NUM_TAPS - 1);
    localparam logic [15:0] SETTLE_END = 16'(SETTLE_CYC - 1);
    localparam logic [15:0] CHECK_END  = 16'(CHECK_CYC - 1);
    localparam logic [5:0]  MIN_LEN    = 6'(MIN_WIN);

    logic [2:0]  state;
    logic [4:0]  tap;
    logic [15:0] cnt;
    logic        err;
    logic [4:0]  cur_start;
    logic [5:0]  cur_len;
    logic [4:0]  best_start;
    logic [5:0]  best_len;

    logic        mismatch;
    logic        tap_good;
    logic        last_tap;
    logic        close_run;
    logic [4:0]  run_start;
    logic [5:0]  run_len;
    logic [4:0]  centre;

    always_comb begin
        mismatch  = (cal.CH1_DATA != PATTERN) || (cal.CH2_DATA != PATTERN) ||
                    (cal.CH3_DATA != PATTERN) || (cal.CH4_DATA != PATTERN);
        tap_good  = !err;
        last_tap  = (tap == LAST_TAP);
        // A good tap opens a run when none is active; the run's length includes this tap.
        run_start = (cur_len == 6'd0) ? tap : cur_start;
        run_len   = tap_good ? (cur_len + 6'd1) : cur_len;
        // The last tap closes any open run: windows never wrap to tap 0.
        close_run = !tap_good || last_tap;
        // best_start + best_len <= 32, so start + len/2 never exceeds 31 and fits the tap width.
        centre    = best_start + 5'(best_len >> 1);
    end

    always_ff @(posedge ADCLK_100M or negedge IO_RST_N) begin
        if (!IO_RST_N) begin
            state           <= ST_IDLE;
            tap             <= 5'd0;
            cnt             <= 16'd0;
            err             <= 1'b0;
            cur_start       <= 5'd0;
            cur_len         <= 6'd0;
            best_start      <= 5'd0;
            best_len        <= 6'd0;
            cal.DLY_TAP_OUT <= DEFAULT_TAP;
            cal.DLY_LD      <= 1'b0;
            cal.CAL_BUSY    <= 1'b0;
            cal.CAL_DONE    <= 1'b0;
            cal.CAL_FAIL    <= 1'b0;
            cal.WIN_START   <= 5'd0;
            cal.WIN_LEN     <= 6'd0;
        end else begin
            case (state)
                ST_IDLE, ST_DONE, ST_FAIL: begin
                    cal.DLY_LD <= 1'b0;
                    if (cal.CAL_START) begin
                        // Tap 0 is loaded on this edge, so the SET_TAP cycle is the load pulse.
                        state           <= ST_SET_TAP;
                        tap             <= 5'd0;
                        cal.DLY_TAP_OUT <= 5'd0;
                        cal.DLY_LD      <= 1'b1;
                        cal.CAL_BUSY    <= 1'b1;
                        cal.CAL_DONE    <= 1'b0;
                        cal.CAL_FAIL    <= 1'b0;
                        cal.WIN_START   <= 5'd0;
                        cal.WIN_LEN     <= 6'd0;
                        cur_start       <= 5'd0;
                        cur_len         <= 6'd0;
                        best_start      <= 5'd0;
                        best_len        <= 6'd0;
                    end
                end

                ST_SET_TAP: begin
                    cal.DLY_LD <= 1'b0;
                    cnt        <= 16'd0;
                    state      <= ST_SETTLE;
                end

                ST_SETTLE: begin
                    if (cnt == SETTLE_END) begin
                        cnt   <= 16'd0;
                        err   <= 1'b0;
                        state <= ST_CHECK;
                    end else begin
                        cnt <= cnt + 16'd1;
                    end
                end

                ST_CHECK: begin
                    err <= err | mismatch;
                    if (cnt == CHECK_END) begin
                        cnt   <= 16'd0;
                        state <= ST_NEXT;
                    end else begin
                        cnt <= cnt + 16'd1;
                    end
                end

                ST_NEXT: begin
                    if (close_run) begin
                        // Strictly longer only: on a tie the earlier window stays best.
                        if (run_len > best_len) begin
                            best_start <= run_start;
                            best_len   <= run_len;
                        end
                        cur_start <= 5'd0;
                        cur_len   <= 6'd0;
                    end else begin
                        cur_start <= run_start;
                        cur_len   <= run_len;
                    end
                    if (last_tap) begin
                        state <= ST_CENTER;
                    end else begin
                        tap             <= tap + 5'd1;
                        cal.DLY_TAP_OUT <= tap + 5'd1;
                        cal.DLY_LD      <= 1'b1;
                        state           <= ST_SET_TAP;
                    end
                end

                ST_CENTER: begin
                    cal.WIN_START <= best_start;
                    cal.WIN_LEN   <= best_len;
                    cal.DLY_LD    <= 1'b1;
                    cal.CAL_BUSY  <= 1'b0;
                    if (best_len >= MIN_LEN) begin
                        tap             <= centre;
                        cal.DLY_TAP_OUT <= centre;
                        cal.CAL_DONE    <= 1'b1;
                        state           <= ST_DONE;
                    end else begin
                        tap             <= DEFAULT_TAP;
                        cal.DLY_TAP_OUT <= DEFAULT_TAP;
                        cal.CAL_FAIL    <= 1'b1;
                        state           <= ST_FAIL;
                    end
                end

                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_adc_dly_tap_cal.sv
// Bench for adc_dly_tap_cal: the ADC pattern model answers per tap from a good-tap mask.
// Latency: expected sweep length 8769 cycles from CAL_BUSY rising to CAL_DONE/CAL_FAIL.
// Backpressure: none; expectations are queued when a sweep starts and popped when it ends.
module tb_adc_dly_tap_cal;

    localparam logic [15:0] PAT = 16'hA55A;

    typedef struct {
        logic       done;
        logic       fail;
        logic [4:0] ws;
        logic [5:0] wl;
        logic [4:0] tap;
        int         cycles;
        int         lds;
    } exp_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    adc_dly_tap_cal_if bus ();

    adc_dly_tap_cal dut (
        .ADCLK_100M (clk),
        .IO_RST_N   (rst_n),
        .cal        (bus)
    );

    int          n_cmp     = 0;
    int          n_fail    = 0;
    logic [31:0] good_mask = '1;
    bit          flip_en   = 1'b0;
    logic [4:0]  flip_tap  = 5'd15;
    int          ld_cnt    = 0;
    int          ld_age    = 0;
    logic [4:0]  prev_tap  = 5'd16;
    exp_t        sb[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_cmp++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
        end
    endtask

    function automatic logic [31:0] rng(input int lo, input int hi);
        logic [31:0] m = '0;
        for (int i = lo; i <= hi; i++) m[i] = 1'b1;
        return m;
    endfunction

    function automatic exp_t mk(input logic d, input logic f, input int ws, input int wl, input int tp);
        exp_t e;
        e.done = d; e.fail = f;
        e.ws = 5'(ws); e.wl = 6'(wl); e.tap = 5'(tp);
        e.cycles = 8769; e.lds = 33;
        return e;
    endfunction

    // Pattern source: on a bad tap one channel (rotating by tap) carries the wrong word.
    // ld_age 17..272 are the CHECK cycles of the tap loaded at age 0.
    always @(negedge clk) begin
        logic [15:0] d [4];
        int ti;
        if (bus.DLY_LD === 1'b1) begin
            ld_cnt++;
            ld_age = 0;
        end else begin
            ld_age++;
        end
        if (rst_n && (bus.DLY_TAP_OUT !== prev_tap))
            chk("tap_change_needs_ld", 32'(bus.DLY_LD), 32'd1);
        prev_tap = bus.DLY_TAP_OUT;
        ti = int'(bus.DLY_TAP_OUT);
        for (int c = 0; c < 4; c++)
            d[c] = (good_mask[ti] || (c != ti % 4)) ? PAT : ~PAT;
        if (flip_en && (bus.DLY_TAP_OUT == flip_tap) && (ld_age == 100))
            d[2] = d[2] ^ 16'h0010;
        bus.CH1_DATA = d[0];
        bus.CH2_DATA = d[1];
        bus.CH3_DATA = d[2];
        bus.CH4_DATA = d[3];
    end

    task automatic wait_tap(input logic [4:0] t, output bit ok);
        ok = 1'b0;
        for (int k = 0; k < 10000; k++) begin
            @(negedge clk);
            if (bus.DLY_LD === 1'b1 && bus.DLY_TAP_OUT === t) begin
                ok = 1'b1;
                break;
            end
        end
        chk("wait_tap_reached", 32'(ok), 32'd1);
    endtask

    task automatic start_cal();
        @(negedge clk);
        bus.CAL_START = 1'b1;
        @(posedge clk);
        #1;
        bus.CAL_START = 1'b0;
        chk("start_busy", 32'(bus.CAL_BUSY), 32'd1);
        chk("start_ld", 32'(bus.DLY_LD), 32'd1);
        chk("start_tap0", 32'(bus.DLY_TAP_OUT), 32'd0);
        chk("start_done_clr", 32'(bus.CAL_DONE), 32'd0);
    endtask

    task automatic run(input string name, input logic [31:0] mask, input bit flip,
                       input int ign_tap, input exp_t e);
        exp_t  x;
        time   t0;
        int    base;
        int    cyc;
        bit    ok;
        $display("run %s", name);
        good_mask = mask;
        flip_en   = flip;
        sb.push_back(e);
        base = ld_cnt;
        start_cal();
        t0 = $time;
        if (ign_tap >= 0) begin
            wait_tap(5'(ign_tap), ok);
            bus.CAL_START = 1'b1;
            @(negedge clk);
            bus.CAL_START = 1'b0;
            chk("ignored_start_busy", 32'(bus.CAL_BUSY), 32'd1);
        end
        ok = 1'b0;
        for (int k = 0; k < 9500; k++) begin
            @(posedge clk);
            #1;
            if (bus.CAL_DONE === 1'b1 || bus.CAL_FAIL === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
        chk("sweep_finished", 32'(ok), 32'd1);
        cyc = int'(($time - t0) / 10);
        @(negedge clk);
        #1;
        x = sb.pop_front();
        chk("done", 32'(bus.CAL_DONE), 32'(x.done));
        chk("fail", 32'(bus.CAL_FAIL), 32'(x.fail));
        chk("busy_end", 32'(bus.CAL_BUSY), 32'd0);
        chk("win_start", 32'(bus.WIN_START), 32'(x.ws));
        chk("win_len", 32'(bus.WIN_LEN), 32'(x.wl));
        chk("final_tap", 32'(bus.DLY_TAP_OUT), 32'(x.tap));
        chk("sweep_cycles", 32'(cyc), 32'(x.cycles));
        chk("ld_pulses", 32'(ld_cnt - base), 32'(x.lds));
        repeat (3) @(posedge clk);
        #1;
        chk("ld_low_after", 32'(bus.DLY_LD), 32'd0);
        chk("flag_sticky", 32'(bus.CAL_DONE | bus.CAL_FAIL), 32'd1);
        flip_en = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit ok;
        bus.CAL_START = 1'b0;
        bus.CH1_DATA  = PAT;
        bus.CH2_DATA  = PAT;
        bus.CH3_DATA  = PAT;
        bus.CH4_DATA  = PAT;
        #1 rst_n = 1'b0;
        #1;
        chk("rst_tap", 32'(bus.DLY_TAP_OUT), 32'd16);
        chk("rst_ld", 32'(bus.DLY_LD), 32'd0);
        chk("rst_busy", 32'(bus.CAL_BUSY), 32'd0);
        chk("rst_done", 32'(bus.CAL_DONE), 32'd0);
        chk("rst_fail", 32'(bus.CAL_FAIL), 32'd0);
        chk("rst_ws", 32'(bus.WIN_START), 32'd0);
        chk("rst_wl", 32'(bus.WIN_LEN), 32'd0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        chk("idle_busy", 32'(bus.CAL_BUSY), 32'd0);

        run("win_10_20", rng(10, 20), 1'b0, -1, mk(1, 0, 10, 11, 15));
        run("two_windows", rng(2, 5) | rng(20, 27), 1'b0, -1, mk(1, 0, 20, 8, 24));
        run("tie_first_wins", rng(0, 5) | rng(20, 25), 1'b0, -1, mk(1, 0, 0, 6, 3));
        run("win_at_top_restart_ignored", rng(26, 31), 1'b0, 8, mk(1, 0, 26, 6, 29));
        run("too_narrow", rng(7, 9), 1'b0, -1, mk(0, 1, 7, 3, 16));
        run("ch3_glitch_tap15", rng(10, 20), 1'b1, -1, mk(1, 0, 10, 5, 12));

        // Abort mid-sweep with reset; no partial result may survive.
        good_mask = '1;
        start_cal();
        wait_tap(5'd20, ok);
        #3 rst_n = 1'b0;
        #1;
        chk("abort_tap", 32'(bus.DLY_TAP_OUT), 32'd16);
        chk("abort_busy", 32'(bus.CAL_BUSY), 32'd0);
        chk("abort_done", 32'(bus.CAL_DONE), 32'd0);
        chk("abort_fail", 32'(bus.CAL_FAIL), 32'd0);
        chk("abort_ld", 32'(bus.DLY_LD), 32'd0);
        chk("abort_wl", 32'(bus.WIN_LEN), 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("abort_idle", 32'(bus.CAL_BUSY), 32'd0);

        run("fresh_all_good", '1, 1'b0, -1, mk(1, 0, 0, 32, 16));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
